// File: rtl/crc_append_pkg.sv
// Shared types and helpers for the crc_append frame stage.
// Holds the frame state enum, the bit-reversal helpers and the CRC-32 check value.
package crc_append_pkg;

  typedef enum logic {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_t;

  localparam logic [31:0] CRC32_CHECK = 32'hcbf4_3926;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [63:0] bitrev_n(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r >> (64 - w);
  endfunction

endpackage

// File: rtl/crc_append_step.sv
// One-byte CRC update, combinational: crc_next = step(crc, data).
// Bit-serial MSB-first shift unrolled over the eight data bits.
module crc_append_step
  import crc_append_pkg::*;
#(
  parameter int                 O_WIDTH = 32,
  parameter logic [O_WIDTH-1:0] POLY    = 32'h04c1_1db7,
  parameter bit                 REFI    = 1'b1
) (
  input  logic [O_WIDTH-1:0] crc,
  input  logic [7:0]         data,
  output logic [O_WIDTH-1:0] crc_next
);

  logic [O_WIDTH-1:0] c;
  logic [7:0]         b;

  always_comb begin
    b = REFI ? bitrev8(data) : data;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[O_WIDTH-2:0], 1'b0} ^ ((c[O_WIDTH-1] ^ b[i]) ? POLY : '0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_append.sv
// Byte-stream frame stage: passes payload through and appends the frame CRC as FCS bytes.
// Optional CRC_APPEND_STATS_EN adds frame_cnt_o, counting fully emitted frames.
module crc_append
  import crc_append_pkg::*;
#(
  parameter bit                 REFI    = 1'b1,
  parameter bit                 REFO    = 1'b1,
  parameter int                 O_WIDTH = 32,
  parameter logic [O_WIDTH-1:0] POLY    = 32'h04c1_1db7,
  parameter logic [O_WIDTH-1:0] INIT    = 32'hffff_ffff,
  parameter logic [O_WIDTH-1:0] XORO    = 32'hffff_ffff
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  input  logic        out_ready_i
`ifdef CRC_APPEND_STATS_EN
  ,
  output logic [31:0] frame_cnt_o
`endif
);

  localparam int NB    = O_WIDTH / 8;
  localparam int IDX_W = 4;

  state_t             state, state_nxt;
  logic [O_WIDTH-1:0] crc, crc_nxt, crc_step;
  logic [O_WIDTH-1:0] fcs, fcs_nxt, fcs_final, fcs_sh;
  logic [63:0]        crc_rev;
  logic [IDX_W-1:0]   idx, idx_nxt, sel;
  logic [7:0]         fcs_byte, data_nxt;
  logic               vld_nxt, last_nxt;
  logic               ld, accept, fcs_last;

  crc_append_step #(
    .O_WIDTH (O_WIDTH),
    .POLY    (POLY),
    .REFI    (REFI)
  ) u_step (
    .crc      (crc),
    .data     (in_data_i),
    .crc_next (crc_step)
  );

  assign ld         = out_ready_i || !out_valid_o;
  assign in_ready_o = ld && (state == PASS);
  assign accept     = in_valid_i && in_ready_o;

  assign crc_rev   = bitrev_n(64'(crc_step), O_WIDTH);
  assign fcs_final = (REFO ? crc_rev[O_WIDTH-1:0] : crc_step) ^ XORO;

  // REFO also fixes wire order: reflected CRCs go out LS byte first.
  assign sel      = REFO ? idx : IDX_W'(NB - 1) - idx;
  assign fcs_sh   = fcs >> {sel, 3'b000};
  assign fcs_byte = fcs_sh[7:0];
  assign fcs_last = (idx == IDX_W'(NB - 1));

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    fcs_nxt   = fcs;
    idx_nxt   = idx;
    data_nxt  = out_data_o;
    vld_nxt   = out_valid_o;
    last_nxt  = out_last_o;
    case (state)
      PASS: begin
        if (accept) begin
          data_nxt = in_data_i;
          vld_nxt  = 1'b1;
          last_nxt = 1'b0;
          crc_nxt  = crc_step;
          if (in_last_i) begin
            fcs_nxt   = fcs_final;
            state_nxt = APPEND;
            idx_nxt   = '0;
          end
        end else if (ld) begin
          vld_nxt = 1'b0;
        end
      end
      APPEND: begin
        if (ld) begin
          data_nxt = fcs_byte;
          vld_nxt  = 1'b1;
          last_nxt = fcs_last;
          idx_nxt  = idx + 1'b1;
          if (fcs_last) begin
            state_nxt = PASS;
            crc_nxt   = INIT;
          end
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= PASS;
      crc         <= INIT;
      fcs         <= '0;
      idx         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      crc         <= crc_nxt;
      fcs         <= fcs_nxt;
      idx         <= idx_nxt;
      out_data_o  <= data_nxt;
      out_valid_o <= vld_nxt;
      out_last_o  <= last_nxt;
    end
  end

`ifdef CRC_APPEND_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_o <= '0;
    end else if (out_valid_o && out_ready_i && out_last_o) begin
      frame_cnt_o <= frame_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc_append.sv
// Scoreboard bench for crc_append: driver pushes model-predicted beats, a monitor pops and compares.
// A second instance configured as CRC-16/XMODEM covers the non-reflected, MS-byte-first path.
module tb_crc_append;
  import crc_append_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;

  logic [7:0] xm_in_data;
  logic       xm_in_valid, xm_in_last, xm_in_ready;
  logic [7:0] xm_out_data;
  logic       xm_out_valid, xm_out_last;
  logic       xm_out_ready;
`ifdef CRC_APPEND_STATS_EN
  logic [31:0] frame_cnt, xm_frame_cnt;
`endif

  always #5 clk = ~clk;

  crc_append dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
`ifdef CRC_APPEND_STATS_EN
    ,
    .frame_cnt_o (frame_cnt)
`endif
  );

  crc_append #(
    .REFI    (1'b0),
    .REFO    (1'b0),
    .O_WIDTH (16),
    .POLY    (16'h1021),
    .INIT    (16'h0000),
    .XORO    (16'h0000)
  ) u_xm (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_data_i   (xm_in_data),
    .in_valid_i  (xm_in_valid),
    .in_last_i   (xm_in_last),
    .in_ready_o  (xm_in_ready),
    .out_data_o  (xm_out_data),
    .out_valid_o (xm_out_valid),
    .out_last_o  (xm_out_last),
    .out_ready_i (xm_out_ready)
`ifdef CRC_APPEND_STATS_EN
    ,
    .frame_cnt_o (xm_frame_cnt)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       win;   // beat is presented while the stage must refuse input
  } exp_t;

  exp_t       exp_q[$];
  int         xfer_cyc[$];
  logic [8:0] xm_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         frames_done = 0;
  bit         ready_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference CRC-32: reflected right-shift form with the reversed polynomial.
  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
    logic [31:0] c = 32'hffff_ffff;
    foreach (b[k]) begin
      c = c ^ {24'h0, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_frame(input logic [7:0] b[$], input bit full);
    logic [31:0] crc;
    exp_t        e;
    crc = crc32_ref(b);
    foreach (b[k]) begin
      e.data = b[k];
      e.last = 1'b0;
      e.win  = full && (k == b.size() - 1);
      exp_q.push_back(e);
    end
    if (full) begin
      for (int i = 0; i < 4; i++) begin
        e.data = crc[8*i +: 8];
        e.last = (i == 3);
        e.win  = (i < 3);
        exp_q.push_back(e);
      end
    end
  endtask

  // Entered and left at posedge+1; inputs stay stable through the following edge.
  task automatic drive_frame(input logic [7:0] b[$], input bit gaps, input bit full);
    bit acc;
    int t;
    push_frame(b, full);
    foreach (b[k]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = b[k];
      in_last  = full && (k == b.size() - 1);
      t = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 200);
      if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive_xm(input logic [7:0] b[$]);
    bit acc;
    int t;
    foreach (b[k]) begin
      xm_in_valid = 1'b1;
      xm_in_data  = b[k];
      xm_in_last  = (k == b.size() - 1);
      t = 0;
      do begin
        @(negedge clk);
        acc = xm_in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 200);
      if (!acc) check("xm_accept_timeout", 64'(acc), 64'd1);
    end
    xm_in_valid = 1'b0;
    xm_in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Downstream back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: compares the presented beat with the scoreboard head.
  initial begin
    bit         stalled = 1'b0;
    logic [7:0] held_d = '0;
    logic       held_l = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(held_d));
          check("stall_last", 64'(out_last), 64'(held_l));
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h last %0b with nothing expected", out_data, out_last);
          end else begin
            e = exp_q[0];
            if (e.win) check("in_ready_during_fcs", 64'(in_ready), 64'd0);
            if (out_ready) begin
              void'(exp_q.pop_front());
              check("out_data", 64'(out_data), 64'(e.data));
              check("out_last", 64'(out_last), 64'(e.last));
              xfer_cyc.push_back(cyc);
              if (out_last) frames_done++;
            end
          end
        end
        stalled = out_valid && !out_ready;
        held_d  = out_data;
        held_l  = out_last;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && xm_out_valid && xm_out_ready) xm_q.push_back({xm_out_last, xm_out_data});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] q[$];
    logic [7:0] one[$];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    one = '{8'h00};
    rst_n        = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    xm_in_data   = '0;
    xm_in_valid  = 1'b0;
    xm_in_last   = 1'b0;
    xm_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
`ifdef CRC_APPEND_STATS_EN
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    check("model_crc32_check", 64'(crc32_ref(s)), 64'(CRC32_CHECK));
    check("model_crc32_single00", 64'(crc32_ref(one)), 64'h0000_0000_d202_ef8d);

    // "123456789", full throughput
    drive_frame(s, 1'b0, 1'b1);
    wait_drain();

    // Single-byte frame
    drive_frame(one, 1'b0, 1'b1);
    wait_drain();

    // Back-pressure
    ready_rand = 1'b1;
    drive_frame(s, 1'b0, 1'b1);
    wait_drain();
    ready_rand = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back frames: 26 beats on consecutive cycles
    xfer_cyc.delete();
    drive_frame(s, 1'b0, 1'b1);
    drive_frame(s, 1'b0, 1'b1);
    wait_drain();
    check("b2b_beats", 64'(xfer_cyc.size()), 64'd26);
    if (xfer_cyc.size() == 26) check("b2b_span", 64'(xfer_cyc[25] - xfer_cyc[0]), 64'd25);

    // Random frames with input gaps and back-pressure
    ready_rand = 1'b1;
    for (int f = 0; f < 15; f++) begin
      q.delete();
      repeat ($urandom_range(1, 16)) q.push_back(8'($urandom_range(0, 255)));
      drive_frame(q, 1'b1, 1'b1);
    end
    wait_drain();
    ready_rand = 1'b0;
    @(posedge clk);
    #1;
`ifdef CRC_APPEND_STATS_EN
    check("frame_cnt_random", 64'(frame_cnt), 64'(frames_done));
`endif

    // Reset after three payload bytes, then a clean frame
    q = '{8'h31, 8'h32, 8'h33};
    drive_frame(q, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    frames_done = 0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_last", 64'(out_last), 64'd0);
    check("midrst_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_frame(s, 1'b0, 1'b1);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_extra_beat", 64'(exp_q.size()), 64'd0);
`ifdef CRC_APPEND_STATS_EN
    check("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);
`endif

    // CRC-16/XMODEM instance
    drive_xm(s);
    repeat (8) @(posedge clk);
    #1;
    check("xm_beats", 64'(xm_q.size()), 64'd11);
    if (xm_q.size() == 11) begin
      check("xm_first", 64'(xm_q[0]), 64'h031);
      check("xm_fcs0", 64'(xm_q[9]), 64'h031);
      check("xm_fcs1", 64'(xm_q[10]), 64'h1c3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
